motor_sequencer: RTL and testbench
==================================

Name: motor_sequencer

Overview:
Sequencing controller for the single-channel H-bridge motor driver pins (AIN1, AIN2, PWMA, STBY).
- Accepts direction/duty commands over a valid/ready handshake.
- Generates PWM on PWMA and manages STBY wake-up and idle sleep.
- Enforces ramp-down plus a brake dead-time before any direction reversal, so the bridge never switches polarity under load.
- Sits between the top-level command logic and the driver pins, replacing the static pin-pattern mapping.

Parameters:
PWM_BITS, 8, width of PWM counter and duty values; period = 2^PWM_BITS clk.
WAKE_CYCLES, 1000, clk cycles STBY is held high before the first PWM output after leaving standby.
DEAD_CYCLES, 500, clk cycles of brake (AIN1=AIN2=1, PWMA=1) between opposite directions.
IDLE_TIMEOUT, 1000000, clk cycles in IDLE before dropping to STANDBY.
RAMP_PERIODS, 4, PWM periods per 1-LSB duty step (ramp feature only).

Ports:
clk  in  1  system clock.
n_rst  in  1  asynchronous reset; active-high (1 = reset), despite the name.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising clk edge.
cmd_dir  in  2  00 coast, 01 forward, 10 reverse, 11 brake.
cmd_duty  in  PWM_BITS  target duty; ignored for coast/brake.
estop  in  1  synchronous emergency stop, level-sensitive.
drv  out  4  {AIN1, AIN2, PWMA, STBY}, same bit order as existing pin map.
busy  out  1  high in WAKE, DRAIN, DEAD.
duty_cur  out  PWM_BITS  duty currently applied.

Behaviour:
- Reset (async, immediate): state=STANDBY, drv=4'b0000, cmd_ready=1, busy=0, duty_cur=0, PWM counter=0, all timers=0.
- PWM: free-running counter wraps 2^PWM_BITS-1 -> 0.
  - In RUN, PWMA = (cnt < duty_cur); duty 0 gives constant 0, max gives (2^N-1)/2^N.
  - duty_cur changes only at the wrap boundary, so no short or runt pulses.
- drv patterns:
  - STANDBY 0000. IDLE/coast 0011. Brake and DEAD 1111. WAKE 0001.
  - RUN forward {1,0,pwm,1}; RUN reverse {0,1,pwm,1}.
- States:
  - STANDBY: on forward/reverse accept -> WAKE. Coast or brake accept -> IDLE.
  - WAKE: STBY=1, counts WAKE_CYCLES, then -> RUN with the latched direction/duty.
  - IDLE: coast (or brake if last command was brake). Timer counts IDLE_TIMEOUT -> STANDBY; any accept clears the timer.
    - Same-or-no prior direction -> RUN directly.
    - Opposite of last run direction -> DEAD.
  - RUN: cmd_ready=1.
    - Same direction: only target duty updated.
    - Opposite direction, coast or brake: target latched -> DRAIN.
  - DRAIN: duty_cur forced toward 0, then:
    - -> DEAD if opposite direction pending.
    - -> IDLE if coast or brake pending (brake pattern held in IDLE for a brake command).
  - DEAD: 1111 for DEAD_CYCLES, then -> RUN with the new direction, duty_cur starting at 0.
- cmd_ready = 0 in WAKE, DRAIN, DEAD; commands are held off, never dropped or overwritten.
- estop:
  - Overrides everything from the next edge: drv=1111, duty_cur=0, pending command discarded, state=IDLE, cmd_ready=0 while estop=1.
  - On release: IDLE with its timer restarted.
  - last-direction memory cleared, so the next run command enters RUN with no DEAD.
- Simultaneous estop and command accept: estop wins, the command is discarded.
- Timers saturate; counter widths use $clog2(param+1).

Optional Feature:
Macro MOTOR_RAMP_EN.
- Defined: in RUN, duty_cur steps ±1 toward target every RAMP_PERIODS PWM periods. DRAIN ramps down at the same rate, then waits for 0. Entry to RUN from WAKE/DEAD/IDLE starts at 0 and ramps up.
- Undefined: duty_cur loads target at the next wrap boundary. DRAIN sets 0 at the next wrap boundary and exits after that boundary.

Test Plan:
- Test parameters: PWM_BITS=4, WAKE_CYCLES=4, DEAD_CYCLES=8, IDLE_TIMEOUT=40, RAMP_PERIODS=1.
- Reset, then fwd duty 8 -> drv 0001 for 4 clk; then AIN1=1, AIN2=0, PWMA high 8 of 16 clk per period (ramp off). n_rst mid-run -> drv 0000 immediately.
- Running fwd duty 15, send rev duty 4 -> cmd_ready low; duty_cur reaches 0 (ramp: 15 periods); 1111 for exactly 8 clk; then AIN1=0, AIN2=1 with duty 4; cmd_ready high again.
- Coast command, no further input -> drv 0011 for 40 clk, then 0000. Next fwd command -> WAKE repeats.
- Hold cmd_valid with a second command during DEAD -> not accepted until RUN; accepted on the first RUN cycle, values intact.
- Assert estop during DRAIN with reverse pending -> next edge drv 1111, duty_cur 0. Release, fwd duty 3 -> RUN with no DEAD interval.
- MOTOR_RAMP_EN defined, fwd duty 5 from IDLE -> duty_cur 1,2,3,4,5 on consecutive wraps; PWMA never changes mid-period.

Source files
------------

// File: rtl/motor_sequencer_if.sv
// Command channel into motor_sequencer: direction/duty qualified by a valid/ready handshake.
interface motor_sequencer_if #(
    parameter int PWM_BITS = 8
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_dir;
    logic [PWM_BITS-1:0] cmd_duty;

    modport master (output cmd_valid, output cmd_dir, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/motor_sequencer.sv
// H-bridge sequencer: PWM generation, STBY wake/sleep and drain + brake dead-time before reversal.
// Optional macro MOTOR_RAMP_EN: duty_cur slews 1 LSB per RAMP_PERIODS PWM periods instead of jumping.
module motor_sequencer #(
    parameter int PWM_BITS     = 8,
    parameter int WAKE_CYCLES  = 1000,
    parameter int DEAD_CYCLES  = 500,
    parameter int IDLE_TIMEOUT = 1000000,
    parameter int RAMP_PERIODS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    motor_sequencer_if.slave    cmd,
    input  logic                estop,
    output logic [3:0]          drv,
    output logic                busy,
    output logic [PWM_BITS-1:0] duty_cur
);
    localparam logic [1:0] DIR_COAST = 2'b00;
    localparam logic [1:0] DIR_FWD   = 2'b01;
    localparam logic [1:0] DIR_REV   = 2'b10;
    localparam logic [1:0] DIR_BRAKE = 2'b11;

    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_SAT  = WAKE_W'(WAKE_CYCLES);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_SAT  = DEAD_W'(DEAD_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_TIMEOUT);

    if (PWM_BITS < 1 || WAKE_CYCLES < 1 || DEAD_CYCLES < 1 ||
        IDLE_TIMEOUT < 1 || RAMP_PERIODS < 1) begin : g_param_check
        $error("motor_sequencer: every parameter must be at least 1");
    end

    typedef enum logic [2:0] {
        ST_STANDBY,
        ST_WAKE,
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DEAD
    } state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] duty_cur_q, duty_cur_d;
    logic [PWM_BITS-1:0] target_q, target_d;
    logic [PWM_BITS-1:0] pend_duty_q, pend_duty_d;
    // dir_q is the active run direction, and after a stop the last one (00 = none)
    logic [1:0]          dir_q, dir_d;
    logic [1:0]          pend_dir_q, pend_dir_d;
    logic                brake_q, brake_d;
    logic [WAKE_W-1:0]   wake_tmr_q, wake_tmr_d;
    logic [DEAD_W-1:0]   dead_tmr_q, dead_tmr_d;
    logic [IDLE_W-1:0]   idle_tmr_q, idle_tmr_d;
    logic [3:0]          drv_q, drv_d;
    logic                busy_q, busy_d;
    logic                cmd_ready_q, cmd_ready_d;

    logic                wrap;
    logic                accept;
    logic                cmd_is_run;
    logic                pend_is_run;
    logic                pwm_d;
    logic [PWM_BITS-1:0] drain_duty;

`ifdef MOTOR_RAMP_EN
    localparam int RAMP_W = $clog2(RAMP_PERIODS + 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
    logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
    logic              ramp_tick;
`endif

    assign wrap        = (cnt_q == {PWM_BITS{1'b1}});
    // estop beats a coincident handshake, so the command is simply never taken
    assign accept      = cmd.cmd_valid && cmd_ready_q && !estop;
    assign cmd_is_run  = (cmd.cmd_dir == DIR_FWD) || (cmd.cmd_dir == DIR_REV);
    assign pend_is_run = (pend_dir_q == DIR_FWD) || (pend_dir_q == DIR_REV);

`ifdef MOTOR_RAMP_EN
    assign ramp_tick = wrap && (ramp_cnt_q == RAMP_LAST);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + PWM_BITS'(1);
        duty_cur_d  = duty_cur_q;
        target_d    = target_q;
        pend_duty_d = pend_duty_q;
        dir_d       = dir_q;
        pend_dir_d  = pend_dir_q;
        brake_d     = brake_q;
        wake_tmr_d  = wake_tmr_q;
        dead_tmr_d  = dead_tmr_q;
        idle_tmr_d  = idle_tmr_q;
        drain_duty  = '0;
`ifdef MOTOR_RAMP_EN
        ramp_cnt_d  = ramp_tick ? '0 : (wrap ? ramp_cnt_q + RAMP_W'(1) : ramp_cnt_q);
        if (ramp_tick && duty_cur_q != '0) begin
            drain_duty = duty_cur_q - PWM_BITS'(1);
        end else begin
            drain_duty = duty_cur_q;
        end
`endif

        case (state_q)
            ST_STANDBY: begin
                if (accept) begin
                    if (cmd_is_run) begin
                        state_d    = ST_WAKE;
                        dir_d      = cmd.cmd_dir;
                        target_d   = cmd.cmd_duty;
                        wake_tmr_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        brake_d    = (cmd.cmd_dir == DIR_BRAKE);
                        idle_tmr_d = '0;
                    end
                end
            end
            ST_WAKE: begin
                if (wake_tmr_q == WAKE_LAST) begin
                    state_d    = ST_RUN;
                    duty_cur_d = '0;
                end else if (wake_tmr_q != WAKE_SAT) begin
                    wake_tmr_d = wake_tmr_q + WAKE_W'(1);
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    idle_tmr_d = '0;
                    if (cmd_is_run) begin
                        brake_d = 1'b0;
                        if (dir_q == DIR_COAST || dir_q == cmd.cmd_dir) begin
                            state_d    = ST_RUN;
                            dir_d      = cmd.cmd_dir;
                            target_d   = cmd.cmd_duty;
                            duty_cur_d = '0;
                        end else begin
                            state_d     = ST_DEAD;
                            pend_dir_d  = cmd.cmd_dir;
                            pend_duty_d = cmd.cmd_duty;
                            dead_tmr_d  = '0;
                        end
                    end else begin
                        brake_d = (cmd.cmd_dir == DIR_BRAKE);
                    end
                end else if (idle_tmr_q == IDLE_LAST) begin
                    state_d = ST_STANDBY;
                    dir_d   = DIR_COAST;
                    brake_d = 1'b0;
                end else if (idle_tmr_q != IDLE_SAT) begin
                    idle_tmr_d = idle_tmr_q + IDLE_W'(1);
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (cmd.cmd_dir == dir_q) begin
                        target_d = cmd.cmd_duty;
                    end else begin
                        state_d     = ST_DRAIN;
                        pend_dir_d  = cmd.cmd_dir;
                        pend_duty_d = cmd.cmd_duty;
                    end
                end
`ifdef MOTOR_RAMP_EN
                if (ramp_tick) begin
                    if (duty_cur_q < target_q) begin
                        duty_cur_d = duty_cur_q + PWM_BITS'(1);
                    end else if (duty_cur_q > target_q) begin
                        duty_cur_d = duty_cur_q - PWM_BITS'(1);
                    end
                end
`else
                if (wrap) begin
                    duty_cur_d = target_q;
                end
`endif
            end
            ST_DRAIN: begin
                // leave on the period boundary that lands duty at zero, never mid-pulse
                if (wrap) begin
                    duty_cur_d = drain_duty;
                    if (drain_duty == '0) begin
                        if (pend_is_run) begin
                            state_d    = ST_DEAD;
                            dead_tmr_d = '0;
                        end else begin
                            state_d    = ST_IDLE;
                            brake_d    = (pend_dir_q == DIR_BRAKE);
                            idle_tmr_d = '0;
                        end
                    end
                end
            end
            ST_DEAD: begin
                if (dead_tmr_q == DEAD_LAST) begin
                    state_d    = ST_RUN;
                    dir_d      = pend_dir_q;
                    target_d   = pend_duty_q;
                    duty_cur_d = '0;
                end else if (dead_tmr_q != DEAD_SAT) begin
                    dead_tmr_d = dead_tmr_q + DEAD_W'(1);
                end
            end
            default: begin
                state_d = ST_STANDBY;
            end
        endcase

        if (estop) begin
            state_d     = ST_IDLE;
            duty_cur_d  = '0;
            target_d    = '0;
            pend_dir_d  = DIR_COAST;
            pend_duty_d = '0;
            dir_d       = DIR_COAST;
            brake_d     = 1'b0;
            idle_tmr_d  = '0;
            wake_tmr_d  = '0;
            dead_tmr_d  = '0;
        end

`ifdef MOTOR_RAMP_EN
        if (state_d == ST_RUN && state_q != ST_RUN) begin
            ramp_cnt_d = '0;
        end
`endif

        // Outputs are computed from next-state values so the registered pins line up with cnt_q.
        pwm_d = (cnt_d < duty_cur_d);
        case (state_d)
            ST_STANDBY: drv_d = 4'b0000;
            ST_WAKE:    drv_d = 4'b0001;
            ST_IDLE:    drv_d = brake_d ? 4'b1111 : 4'b0011;
            ST_RUN,
            ST_DRAIN:   drv_d = {dir_d[0], dir_d[1], pwm_d, 1'b1};
            ST_DEAD:    drv_d = 4'b1111;
            default:    drv_d = 4'b0000;
        endcase
        if (estop) begin
            drv_d = 4'b1111;
        end
        busy_d      = (state_d == ST_WAKE) || (state_d == ST_DRAIN) || (state_d == ST_DEAD);
        cmd_ready_d = !estop &&
                      ((state_d == ST_STANDBY) || (state_d == ST_IDLE) || (state_d == ST_RUN));
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q     <= ST_STANDBY;
            cnt_q       <= '0;
            duty_cur_q  <= '0;
            target_q    <= '0;
            pend_duty_q <= '0;
            dir_q       <= DIR_COAST;
            pend_dir_q  <= DIR_COAST;
            brake_q     <= 1'b0;
            wake_tmr_q  <= '0;
            dead_tmr_q  <= '0;
            idle_tmr_q  <= '0;
            drv_q       <= 4'b0000;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
`ifdef MOTOR_RAMP_EN
            ramp_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            duty_cur_q  <= duty_cur_d;
            target_q    <= target_d;
            pend_duty_q <= pend_duty_d;
            dir_q       <= dir_d;
            pend_dir_q  <= pend_dir_d;
            brake_q     <= brake_d;
            wake_tmr_q  <= wake_tmr_d;
            dead_tmr_q  <= dead_tmr_d;
            idle_tmr_q  <= idle_tmr_d;
            drv_q       <= drv_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
`ifdef MOTOR_RAMP_EN
            ramp_cnt_q  <= ramp_cnt_d;
`endif
        end
    end

    assign drv           = drv_q;
    assign busy          = busy_q;
    assign duty_cur      = duty_cur_q;
    assign cmd.cmd_ready = cmd_ready_q;
endmodule

// File: tb/tb_motor_sequencer.sv
// Directed bench for motor_sequencer with small timing parameters; compile with MOTOR_RAMP_EN for ramp mode.
module tb_motor_sequencer;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          estop;
    logic [3:0]    drv;
    logic          busy;
    logic [PW-1:0] duty_cur;
    int            checks = 0;
    int            errors = 0;

    motor_sequencer_if #(.PWM_BITS(PW)) bus ();

    motor_sequencer #(
        .PWM_BITS    (PW),
        .WAKE_CYCLES (4),
        .DEAD_CYCLES (8),
        .IDLE_TIMEOUT(40),
        .RAMP_PERIODS(1)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .cmd     (bus),
        .estop   (estop),
        .drv     (drv),
        .busy    (busy),
        .duty_cur(duty_cur)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [1:0] dir, input logic [PW-1:0] duty);
        int t;
        t = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_duty  = duty;
        while (bus.cmd_ready !== 1'b1 && t < 400) begin
            cyc(1);
            t++;
        end
        chk("send_ready", 32'(bus.cmd_ready), 1);
        cyc(1);
        bus.cmd_valid = 1'b0;
        $display("cmd dir=%b duty=%0d accepted after %0d wait cycles, drv=%b", dir, duty, t, drv);
    endtask

    task automatic wait_duty(input string tag, input logic [PW-1:0] val);
        int t;
        t = 0;
        while (duty_cur !== val && t < 400) begin
            cyc(1);
            t++;
        end
        chk(tag, 32'(duty_cur), 32'(val));
    endtask

    initial begin
        int hi;
        int bad;
        int n;
        int t;

        n_rst = 1'b1;
        estop = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 2'b00;
        bus.cmd_duty  = '0;
        cyc(3);
        chk("reset_drv", 32'(drv), 4'b0000);
        chk("reset_ready", 32'(bus.cmd_ready), 1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_duty", 32'(duty_cur), 0);
        n_rst = 1'b0;
        cyc(1);

        // Wake from standby, then forward at half duty
        send(2'b01, 4'd8);
        chk("wake_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            chk("wake_drv", 32'(drv), 4'b0001);
            cyc(1);
        end
        chk("run_entry_drv", 32'(drv), 4'b1001);
        chk("run_entry_busy", 32'(busy), 0);
        chk("run_entry_ready", 32'(bus.cmd_ready), 1);
        wait_duty("fwd8_duty", 4'd8);
        hi = 0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (drv !== ((i < 8) ? 4'b1011 : 4'b1001)) bad++;
            if (drv[1] === 1'b1) hi++;
            cyc(1);
        end
        chk("fwd8_high_count", hi, 8);
        chk("fwd8_pattern_bad", bad, 0);

        // Asynchronous reset mid-run
        #2 n_rst = 1'b1;
        #1;
        chk("async_rst_drv", 32'(drv), 4'b0000);
        chk("async_rst_duty", 32'(duty_cur), 0);
        chk("async_rst_ready", 32'(bus.cmd_ready), 1);
        cyc(1);
        n_rst = 1'b0;
        cyc(1);

        // Reversal: drain, 8-cycle brake, then reverse
        send(2'b01, 4'd15);
        cyc(4);
        wait_duty("fwd15_duty", 4'd15);
        send(2'b10, 4'd4);
        chk("drain_ready", 32'(bus.cmd_ready), 0);
        chk("drain_busy", 32'(busy), 1);
        wait_duty("drain_zero", 4'd0);
        for (int i = 0; i < 8; i++) begin
            chk("dead_drv", 32'(drv), 4'b1111);
            cyc(1);
        end
        chk("rev_entry_drv", 32'(drv), 4'b0101);
        chk("rev_entry_ready", 32'(bus.cmd_ready), 1);
        wait_duty("rev4_duty", 4'd4);
        chk("rev4_dir", 32'(drv[3:2]), 2'b01);

        // Command held through drain and dead-time is taken on the first RUN cycle
        send(2'b01, 4'd6);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = 2'b01;
        bus.cmd_duty  = 4'd11;
        n = 0;
        t = 0;
        while (bus.cmd_ready !== 1'b1 && t < 400) begin
            if (drv === 4'b1111) n++;
            cyc(1);
            t++;
        end
        chk("hold_dead_len", n, 8);
        chk("hold_first_run_drv", 32'(drv), 4'b1001);
        cyc(1);
        bus.cmd_valid = 1'b0;
        $display("cmd dir=01 duty=11 accepted on first RUN cycle, drv=%b", drv);
        chk("hold_ready_after", 32'(bus.cmd_ready), 1);
        chk("hold_busy_after", 32'(busy), 0);
        t = 0;
        while (duty_cur === '0 && t < 400) begin
            cyc(1);
            t++;
        end
`ifdef MOTOR_RAMP_EN
        chk("hold_first_duty", 32'(duty_cur), 1);
`else
        chk("hold_first_duty", 32'(duty_cur), 11);
`endif
        wait_duty("hold_target", 4'd11);

        // Coast, idle timeout to standby, then wake again
        send(2'b00, 4'd0);
        t = 0;
        while (drv !== 4'b0011 && t < 400) begin
            cyc(1);
            t++;
        end
        n = 0;
        while (drv === 4'b0011 && n < 100) begin
            n++;
            cyc(1);
        end
        chk("idle_len", n, 40);
        chk("standby_drv", 32'(drv), 4'b0000);
        send(2'b01, 4'd5);
        chk("rewake_drv", 32'(drv), 4'b0001);
        chk("rewake_busy", 32'(busy), 1);
        cyc(4);
        chk("rewake_run_drv", 32'(drv), 4'b1001);

        // Emergency stop while draining toward a reversal
        wait_duty("fwd5_duty", 4'd5);
        send(2'b10, 4'd2);
        chk("estop_pre_busy", 32'(busy), 1);
        estop = 1'b1;
        cyc(1);
        chk("estop_drv", 32'(drv), 4'b1111);
        chk("estop_duty", 32'(duty_cur), 0);
        chk("estop_busy", 32'(busy), 0);
        chk("estop_ready", 32'(bus.cmd_ready), 0);
        cyc(2);
        chk("estop_hold_drv", 32'(drv), 4'b1111);
        estop = 1'b0;
        cyc(1);
        chk("estop_rel_drv", 32'(drv), 4'b0011);
        chk("estop_rel_ready", 32'(bus.cmd_ready), 1);
        send(2'b01, 4'd3);
        chk("estop_run_drv", 32'(drv), 4'b1001);
        chk("estop_run_busy", 32'(busy), 0);
`ifdef MOTOR_RAMP_EN
        t = 0;
        while (duty_cur === '0 && t < 400) begin
            cyc(1);
            t++;
        end
        chk("ramp_step1", 32'(duty_cur), 1);
        cyc(8);
        chk("ramp_mid_period", 32'(duty_cur), 1);
        cyc(8);
        chk("ramp_step2", 32'(duty_cur), 2);
        cyc(16);
        chk("ramp_step3", 32'(duty_cur), 3);
`else
        wait_duty("fwd3_duty", 4'd3);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            if (drv === 4'b1011) hi++;
            cyc(1);
        end
        chk("fwd3_high_count", hi, 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
